imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
Instruction-memory responder serving the fetch stage of the pipelined core over a valid/ready request/response handshake. It replaces the combinational instruction ROM with a word-addressed array that has a configurable fixed read latency, fault reporting and a flush input driven by the redirect logic. A side-band load port lets the bench or a boot loader write program words.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr/rsp_addr
INSTR_WIDTH, 32, instruction word width
DEPTH_LOG2, 10, log2 of word count (1024 words)
LATENCY, 2, cycles from request accept to rsp_valid; legal 1..4
BASE_ADDR, 0, byte address of word 0

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  fetch presents a PC
req_ready  out  1  responder accepts the request this cycle
req_addr  in  ADDR_WIDTH  byte address (PC)
flush  in  1  kill any in-flight or held response (pipeline redirect)
rsp_valid  out  1  response held valid
rsp_ready  in  1  fetch consumes the response
rsp_instr  out  INSTR_WIDTH  instruction word
rsp_addr  out  ADDR_WIDTH  echo of accepted req_addr
rsp_fault  out  1  misaligned or out-of-range access
ld_en  in  1  write one word into the array
ld_addr  in  ADDR_WIDTH  byte address of the load word
ld_data  in  INSTR_WIDTH  data for the load word

Behaviour:
- One clock (clk). reset is asynchronous and active-high. FSM states: IDLE, BUSY, RESP.
- Reset (async, any state, mid-transaction included): state=IDLE; count=0; rsp_valid=0; rsp_instr=32'h00000013 (NOP); rsp_addr=0; rsp_fault=0. Any in-flight transaction is dropped. Array contents are not reset.
- req_ready = ~flush & (state==IDLE | (state==RESP & rsp_ready)). A request is accepted when req_valid & req_ready.
- Accept at edge t: capture req_addr, a fault flag and the array word addressed by (req_addr-BASE_ADDR)[DEPTH_LOG2+1:2]. The word is a snapshot at acceptance: an ld_en to the same word in the accept cycle returns the old value.
- Fault: req_addr[1:0]!=0, req_addr<BASE_ADDR, or (req_addr-BASE_ADDR)>>2 >= 2^DEPTH_LOG2. On fault, rsp_fault=1 and rsp_instr=NOP.
- LATENCY=1: go directly to RESP, with rsp_valid high in cycle t+1. LATENCY>1: go to BUSY with count=LATENCY-1, decrement each cycle, and enter RESP when count reaches 1. rsp_valid first rises LATENCY cycles after accept.
- RESP: rsp_valid, rsp_instr, rsp_addr and rsp_fault stay stable until rsp_ready. On rsp_ready without a new accept, go to IDLE and drop rsp_valid. On rsp_ready with a new accept (back-to-back), restart the latency pipeline. rsp_valid drops for LATENCY-1 cycles (stays high if LATENCY=1 with new data).
- flush (highest priority after reset): from BUSY or RESP, go to IDLE next edge with rsp_valid=0 and count=0. A request in the flush cycle is not accepted. A response that is valid and ready in the flush cycle is still counted as consumed.
- Load port: when ld_en, write ld_data at the word index of ld_addr in that edge. Misaligned or out-of-range ld_addr is ignored. Loads are independent of FSM state.
- Only one transaction is outstanding at a time. req_addr is not required to be stable after accept.

Test Plan:
- Reset mid-BUSY: accept 0x8, assert reset one cycle later -> rsp_valid=0, rsp_instr=0x00000013 immediately; IDLE after release.
- Latency: load 0x00500093 at 0x4 with LATENCY=2, request 0x4 accepted at cycle 10 -> rsp_valid at cycle 12, rsp_instr=0x00500093, rsp_addr=0x4, rsp_fault=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0. Set rsp_ready=1 with req_valid at 0x8 -> back-to-back accept, and the next response arrives 2 cycles later.
- Faults: request 0x6 -> rsp_fault=1, instr=NOP. Request 0x1000 (DEPTH_LOG2=10) -> rsp_fault=1.
- Flush: flush during BUSY -> no response, IDLE next cycle. Flush with req_valid high -> req_ready=0, no accept.
- Load snapshot: ld_en to 0x4 (0xDEADBEEF) in the same cycle as accept of 0x4 -> old word returned. A re-request returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch <-> instruction-memory bus: request/response handshake, redirect flush
// and the side-band program-load port.
interface imem_responder_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   flush;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [INSTR_WIDTH-1:0] rsp_instr;
    logic [ADDR_WIDTH-1:0]  rsp_addr;
    logic                   rsp_fault;
    logic                   ld_en;
    logic [ADDR_WIDTH-1:0]  ld_addr;
    logic [INSTR_WIDTH-1:0] ld_data;

    // Responder side.
    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    // Fetch / loader side.
    modport master (
        output req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed array with a fixed read latency,
// misalignment/range fault reporting, redirect flush and a program-load port.
// One transaction is outstanding at a time; the response is held until consumed.
module imem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH_LOG2  = 10,
    parameter int                    LATENCY     = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input logic              clk,
    input logic              reset,
    imem_responder_if.slave  bus
);

    localparam int                     DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [INSTR_WIDTH-1:0] NOP      = INSTR_WIDTH'(32'h0000_0013);
    // Byte span covered by the array, starting at BASE_ADDR.
    localparam logic [ADDR_WIDTH-1:0]  SPAN     = ADDR_WIDTH'(64'd1 << (DEPTH_LOG2 + 2));
    localparam logic [2:0]             CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Word-aligned and inside [BASE_ADDR, BASE_ADDR + SPAN).
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       accept;
    logic       req_ok;

    logic [INSTR_WIDTH-1:0] rsp_instr_q;
    logic [ADDR_WIDTH-1:0]  rsp_addr_q;
    logic                   rsp_fault_q;

    assign bus.req_ready = ~bus.flush &
                           ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
    assign accept        = bus.req_valid & bus.req_ready;
    assign req_ok        = addr_ok(bus.req_addr);

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_fault = rsp_fault_q;

    // Next state: flush wins, then a new accept restarts the latency countdown.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (bus.flush) begin
            state_d = IDLE;
            count_d = '0;
        end else if (accept) begin
            if (LATENCY == 1) begin
                state_d = RESP;
                count_d = '0;
            end else begin
                state_d = BUSY;
                count_d = CNT_INIT;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (count_q == 3'd1) begin
                        state_d = RESP;
                        count_d = '0;
                    end else begin
                        count_d = count_q - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Snapshot the response on accept; it then stays put until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_instr_q <= NOP;
            rsp_addr_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else if (accept) begin
            rsp_addr_q  <= bus.req_addr;
            rsp_fault_q <= ~req_ok;
            rsp_instr_q <= req_ok ? mem[word_idx(bus.req_addr)] : NOP;
        end
    end

    // Program load; the read above sees the pre-write word in the same cycle.
    always_ff @(posedge clk) begin
        if (bus.ld_en && addr_ok(bus.ld_addr)) begin
            mem[word_idx(bus.ld_addr)] <= bus.ld_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares whatever the responder presents.
module tb_imem_responder;

    localparam int          LAT = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    logic started = 1'b0;

    always #5 clk = ~clk;

    imem_responder_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    imem_responder #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .DEPTH_LOG2 (10),
        .LATENCY    (LAT),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [1024];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit ref_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'd1024);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; also checks handshake timing against the queue model.
    task automatic drive(input logic rv, input logic [31:0] a, input logic fl, input logic rr,
                         input logic le, input logic [31:0] la, input logic [31:0] ldv);
        exp_t e;
        logic ev;
        logic er;
        @(posedge clk);
        #1;
        bus.req_valid = rv;
        bus.req_addr  = a;
        bus.flush     = fl;
        bus.rsp_ready = rr;
        bus.ld_en     = le;
        bus.ld_addr   = la;
        bus.ld_data   = ldv;
        #2;
        ev = (q.size() > 0) && ((cyc - q[0].acc) >= LAT);
        er = !fl && ((q.size() == 0) || (ev && rr));
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, er});
        if (rv && er) begin
            e.addr  = a;
            e.fault = !ref_ok(a);
            e.instr = e.fault ? NOP : mm[a[11:2]];
            e.acc   = cyc;
            q.push_back(e);
        end
        if (le && ref_ok(la)) mm[la[11:2]] = ldv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic req(input logic [31:0] a);
        drive(1'b1, a, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, 63)) << 2;
        else if (r == 7) return (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 8) return 32'h1000 + (32'($urandom_range(0, 15)) << 2);
        else             return $urandom;
    endfunction

    // Monitor: compare the held response every cycle it is valid, pop on consume.
    always @(negedge clk) begin
        if (started && !rst) begin
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_rsp actual=valid required=idle (t=%0t)", $time);
                end else begin
                    chk("rsp_addr",  bus.rsp_addr, q[0].addr);
                    chk("rsp_instr", bus.rsp_instr, q[0].instr);
                    chk("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, q[0].fault});
                    if (bus.rsp_ready) void'(q.pop_front());
                end
            end
            if (bus.flush) q.delete();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_instr", bus.rsp_instr, NOP);
        chk("reset_rsp_addr",  bus.rsp_addr, 32'd0);
        chk("reset_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        // Preload the first 64 words.
        for (int i = 0; i < 64; i++)
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'(i) << 2, $urandom);
        // Misaligned and out-of-range loads must not alias onto word 0.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'hBAD0_BAD0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 32'hBAD1_BAD1);
        req(32'h0);
        idle(3);

        // Latency
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0050_0093);
        req(32'h4);
        idle(3);

        // Backpressure then back-to-back accept
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(4);

        // Faults
        req(32'h6);
        idle(3);
        req(32'h1000);
        idle(3);
        req(32'hFFFF_FFFC);
        idle(3);

        // Flush in BUSY, flush in held RESP, flush with a request in IDLE
        req(32'hC);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(3);
        req(32'hC);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);
        drive(1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Load in the accept cycle returns the old word; re-request sees the new one
        drive(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF);
        idle(3);
        req(32'h4);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        rv, fl, rr, le;
            logic [31:0] a, la;
            rv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 19) == 0);
            le = ($urandom_range(0, 4) == 0);
            a  = pick_addr();
            la = pick_addr();
            drive(rv, a, fl, rr, le, la, $urandom);
        end
        idle(4);

        // Reset one cycle after accept, mid-BUSY
        req(32'h8);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("midreset_rsp_instr", bus.rsp_instr, NOP);
        chk("midreset_rsp_addr",  bus.rsp_addr, 32'd0);
        chk("midreset_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        req(32'h8);
        idle(6);

        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
